// File: rtl/ws2812_frame_scheduler.sv
`default_nettype none
// ============================================================================
// ws2812_frame_scheduler : fetches GRB pixels over req/valid and serialises one
// WS2812 frame followed by the latch period. Option macro: WS2812_PREFETCH_EN.
// Revision: 1.0
// ============================================================================
module ws2812_frame_scheduler #(
  parameter int NUM_LEDS     = 8,
  parameter int T0H_CYCLES   = 20,
  parameter int T1H_CYCLES   = 40,
  parameter int TBIT_CYCLES  = 63,
  parameter int RESET_CYCLES = 2500,
  localparam int IDX_W       = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_pix_req,
  output logic [IDX_W-1:0] o_pix_idx,
  input  logic             i_pix_valid,
  input  logic [23:0]      i_pix_data,
  output logic             o_serial,
  output logic             o_frame_done
);

  localparam int CNT_MAX = (TBIT_CYCLES > RESET_CYCLES) ? TBIT_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < TBIT_CYCLES &&
        RESET_CYCLES >= 1 && NUM_LEDS >= 1)) begin : g_param_check
    $fatal(1, "ws2812_frame_scheduler: illegal timing/size parameters");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_SEND, ST_LATCH} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt, w_idx_inc, w_pix_idx_nxt;
  logic [23:0]      r_shift, w_shift_nxt;
  logic [4:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [CNT_W-1:0] r_cyc_cnt, w_cyc_cnt_nxt, w_cyc_inc, w_th;
  logic             w_busy_nxt, w_pix_req_nxt, w_serial_nxt, w_frame_done_nxt;
  logic             w_cell_end, w_last_pix;
`ifdef WS2812_PREFETCH_EN
  logic [23:0]      r_hold, w_hold_nxt;
  logic             r_hold_vld, w_hold_vld_nxt, w_accept;

  assign w_accept = o_pix_req & i_pix_valid;
`endif

  assign w_idx_inc  = r_idx + IDX_W'(1);
  assign w_cyc_inc  = r_cyc_cnt + CNT_W'(1);
  assign w_cell_end = (r_cyc_cnt == CNT_W'(TBIT_CYCLES - 1));
  assign w_last_pix = (r_idx == IDX_W'(NUM_LEDS - 1));
  assign w_th       = r_shift[23] ? CNT_W'(T1H_CYCLES) : CNT_W'(T0H_CYCLES);

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_shift_nxt      = r_shift;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_cyc_cnt_nxt    = r_cyc_cnt;
    w_busy_nxt       = o_busy;
    w_pix_req_nxt    = o_pix_req;
    w_pix_idx_nxt    = o_pix_idx;
    w_serial_nxt     = 1'b0;
    w_frame_done_nxt = 1'b0;
`ifdef WS2812_PREFETCH_EN
    w_hold_nxt       = r_hold;
    w_hold_vld_nxt   = r_hold_vld;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt   = ST_FETCH;
          w_idx_nxt     = '0;
          w_busy_nxt    = 1'b1;
          w_pix_req_nxt = 1'b1;
          w_pix_idx_nxt = '0;
        end
      end
      ST_FETCH: begin
        if (i_pix_valid) begin
          w_state_nxt   = ST_SEND;
          w_shift_nxt   = i_pix_data;
          w_bit_cnt_nxt = 5'd23;
          w_cyc_cnt_nxt = '0;
          w_serial_nxt  = 1'b1;
          w_pix_req_nxt = 1'b0;
`ifdef WS2812_PREFETCH_EN
          if (!w_last_pix) begin
            w_pix_req_nxt = 1'b1;
            w_pix_idx_nxt = w_idx_inc;
          end
`endif
        end
      end
      ST_SEND: begin
`ifdef WS2812_PREFETCH_EN
        if (w_accept) begin
          w_hold_nxt     = i_pix_data;
          w_hold_vld_nxt = 1'b1;
          w_pix_req_nxt  = 1'b0;
        end
`endif
        // Output is registered, so the level is decided for the next cycle's count.
        if (!w_cell_end) begin
          w_cyc_cnt_nxt = w_cyc_inc;
          w_serial_nxt  = (w_cyc_inc < w_th);
        end else if (r_bit_cnt != 5'd0) begin
          w_bit_cnt_nxt = r_bit_cnt - 5'd1;
          w_shift_nxt   = {r_shift[22:0], 1'b0};
          w_cyc_cnt_nxt = '0;
          w_serial_nxt  = 1'b1;
        end else if (w_last_pix) begin
          w_state_nxt      = ST_LATCH;
          w_cyc_cnt_nxt    = '0;
          w_frame_done_nxt = (RESET_CYCLES == 1);
`ifdef WS2812_PREFETCH_EN
        end else if (r_hold_vld || w_accept) begin
          w_idx_nxt      = w_idx_inc;
          w_shift_nxt    = r_hold_vld ? r_hold : i_pix_data;
          w_hold_vld_nxt = 1'b0;
          w_bit_cnt_nxt  = 5'd23;
          w_cyc_cnt_nxt  = '0;
          w_serial_nxt   = 1'b1;
          w_pix_req_nxt  = (w_idx_inc != IDX_W'(NUM_LEDS - 1));
          w_pix_idx_nxt  = w_idx_inc + IDX_W'(1);
`endif
        end else begin
          w_state_nxt   = ST_FETCH;
          w_idx_nxt     = w_idx_inc;
          w_pix_req_nxt = 1'b1;
          w_pix_idx_nxt = w_idx_inc;
        end
      end
      ST_LATCH: begin
        if (r_cyc_cnt == CNT_W'(RESET_CYCLES - 1)) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_cyc_cnt_nxt    = w_cyc_inc;
          w_frame_done_nxt = (w_cyc_inc == CNT_W'(RESET_CYCLES - 1));
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_cyc_cnt    <= '0;
      o_busy       <= 1'b0;
      o_pix_req    <= 1'b0;
      o_pix_idx    <= '0;
      o_serial     <= 1'b0;
      o_frame_done <= 1'b0;
`ifdef WS2812_PREFETCH_EN
      r_hold       <= '0;
      r_hold_vld   <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_cyc_cnt    <= w_cyc_cnt_nxt;
      o_busy       <= w_busy_nxt;
      o_pix_req    <= w_pix_req_nxt;
      o_pix_idx    <= w_pix_idx_nxt;
      o_serial     <= w_serial_nxt;
      o_frame_done <= w_frame_done_nxt;
`ifdef WS2812_PREFETCH_EN
      r_hold       <= w_hold_nxt;
      r_hold_vld   <= w_hold_vld_nxt;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_scheduler.sv
`default_nettype none
// ============================================================================
// tb_ws2812_frame_scheduler : directed + randomized frames against a queue model
// of the expected serial waveform. Revision: 1.0
// ============================================================================
module tb_ws2812_frame_scheduler;

  localparam int N     = 2;
  localparam int T0H   = 4;
  localparam int T1H   = 8;
  localparam int TBIT  = 12;
  localparam int RST   = 50;
  localparam int CELLS = 24 * TBIT;
`ifdef WS2812_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset_n, i_start, i_pix_valid;
  logic [23:0] i_pix_data;
  logic        o_busy, o_pix_req, o_serial, o_frame_done;
  logic [0:0]  o_pix_idx;

  ws2812_frame_scheduler #(
    .NUM_LEDS(N), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
    .TBIT_CYCLES(TBIT), .RESET_CYCLES(RST)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start), .o_busy(o_busy),
    .o_pix_req(o_pix_req), .o_pix_idx(o_pix_idx), .i_pix_valid(i_pix_valid),
    .i_pix_data(i_pix_data), .o_serial(o_serial), .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: queue of expected line levels and done flags, one entry per cycle.
  bit q_ser[$];
  bit q_done[$];
  int accepted = 0;
  bit exp_busy = 0, exp_req = 0, exp_ser = 0, exp_done = 0, last_done = 0;
  logic [23:0] pix [N];
  int dly [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pixel(input logic [23:0] d);
    for (int b = 23; b >= 0; b--)
      for (int c = 0; c < TBIT; c++) begin
        q_ser.push_back(c < (d[b] ? T1H : T0H));
        q_done.push_back(1'b0);
      end
    accepted++;
    if (accepted == N)
      for (int c = 0; c < RST; c++) begin
        q_ser.push_back(1'b0);
        q_done.push_back(c == RST - 1);
      end
  endtask

  task automatic step();
    @(posedge i_clk);
    if (!i_reset_n) begin
      q_ser.delete(); q_done.delete();
      accepted = 0; exp_busy = 0; last_done = 0;
    end else begin
      if (i_start && !exp_busy) begin
        exp_busy = 1; accepted = 0;
      end else if (last_done) exp_busy = 0;
      if (i_pix_valid && exp_req) push_pixel(i_pix_data);
    end
    #1;
    exp_req  = exp_busy && accepted < N &&
               (q_ser.size() == 0 || (PREFETCH && q_ser.size() <= CELLS));
    exp_ser  = (q_ser.size() != 0) ? q_ser[0] : 1'b0;
    exp_done = (q_done.size() != 0) ? q_done[0] : 1'b0;
    chk("serial", 32'(o_serial), 32'(exp_ser));
    chk("busy", 32'(o_busy), 32'(exp_busy));
    chk("pix_req", 32'(o_pix_req), 32'(exp_req));
    chk("frame_done", 32'(o_frame_done), 32'(exp_done));
    if (exp_req) chk("pix_idx", 32'(o_pix_idx), 32'(accepted));
    if (!i_reset_n) chk("reset_idx", 32'(o_pix_idx), 32'd0);
    if (q_ser.size() != 0) begin
      void'(q_ser.pop_front());
      void'(q_done.pop_front());
    end
    last_done = exp_done;
  endtask

  // mode 0: plain frame; 1: stray starts mid-SEND and on done; 2: reset in bit 5 of pixel 0
  task automatic run_frame(input logic [23:0] p0, input logic [23:0] p1,
                           input int d0, input int d1, input int mode);
    int wait_cnt = 0;
    pix[0] = p0; pix[1] = p1; dly[0] = d0; dly[1] = d1;
    i_start = 1'b1;
    step();
    for (int cyc = 0; cyc < 3000 && exp_busy; cyc++) begin
      i_start = 1'b0;
      i_pix_valid = 1'b0;
      if (exp_req) begin
        if (wait_cnt >= dly[accepted]) begin
          i_pix_valid = 1'b1;
          i_pix_data  = pix[accepted];
          wait_cnt    = 0;
        end else wait_cnt++;
      end
      if (mode == 1 && (q_ser.size() == 100 || last_done)) i_start = 1'b1;
      if (mode == 2 && accepted == 1 && q_ser.size() == CELLS - 5 * TBIT - 3) i_reset_n = 1'b0;
      step();
      if (!i_reset_n) i_reset_n = 1'b1;
    end
    chk("frame_timeout", 32'(o_busy), 32'd0);
    i_start = 1'b0;
    i_pix_valid = 1'b0;
  endtask

  initial begin
    i_reset_n = 1'b0; i_start = 1'b0; i_pix_valid = 1'b0; i_pix_data = '0;
    step(); step();
    i_reset_n = 1'b1;
    step();
    run_frame(24'hFF0000, 24'h00000F, 1, 1, 0);
    run_frame(24'($urandom), 24'($urandom), 1, 10, 0);
    run_frame(24'($urandom), 24'($urandom), 0, 2, 1);
    i_pix_valid = 1'b1; i_pix_data = 24'hAAAAAA;
    step();
    i_pix_valid = 1'b0;
    step();
    run_frame(24'h5A5A5A, 24'hC3C3C3, 0, 0, 0);
    run_frame(24'h123456, 24'($urandom), 1, 1, 2);
    run_frame(24'h654321, 24'h0F0F0F, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      run_frame(24'($urandom), 24'($urandom), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), 0);
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
